// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file bus defines plus the write-back arbiter package.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
//
// Defines: BUS_ADDR_REG / BUS_DATA_REG are packed ranges for register
// addresses and data. REG_ADDR_ZERO is x0. ZERO_WORD is the all-zero data
// word. REG_WR_EN is the asserted level of the register file write enable.
`ifndef REG_WB_SHARED_DEFINES
`define REG_WB_SHARED_DEFINES
`define BUS_ADDR_REG   4:0
`define BUS_DATA_REG   31:0
`define REG_ADDR_ZERO  5'd0
`define ZERO_WORD      32'h0000_0000
`define REG_WR_EN      1'b1
`endif

package reg_wb_arbiter_pkg;

    // Default sizing of the port B buffer and its starvation limit.
    localparam int WB_DEPTH      = 4;
    localparam int WB_STARVE_MAX = 3;

    // One buffered port B result. kill marks an entry that must pop
    // without writing, either because it targets x0 or because a younger
    // port A write to the same register already overtook it.
    typedef struct packed {
        logic [`BUS_ADDR_REG] addr;
        logic [`BUS_DATA_REG] data;
        logic                 kill;
    } wb_entry_t;

    function automatic logic is_x0(input logic [`BUS_ADDR_REG] addr);
        return addr == `REG_ADDR_ZERO;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: circular buffer of port B results with per-entry kill flags.
// Latency: a push is visible (head/entry views) from the next cycle; pop is same-cycle.
// Backpressure: caller must not push while full; full is not relieved by a same-cycle pop.
//
// Ports: clk/rst (async active-high); push + push_ent enqueue; pop dequeues
// the head; kill_en + kill_addr set kill on every stored entry whose address
// matches; head is the oldest entry; empty/full status; ent_live/ent_addr
// (and ent_data with WB_FORWARD_EN) give every slot in age order, index 0
// being the oldest, so the caller can do youngest-match searches.
module wb_fifo
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  wb_entry_t            push_ent,
    input  logic                 pop,
    input  logic                 kill_en,
    input  logic [`BUS_ADDR_REG] kill_addr,
    output wb_entry_t            head,
    output logic                 empty,
    output logic                 full,
    output logic                 ent_live [DEPTH],
    output logic [`BUS_ADDR_REG] ent_addr [DEPTH]
`ifdef WB_FORWARD_EN
    ,
    output logic [`BUS_DATA_REG] ent_data [DEPTH]
`endif
);

    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // Squash matching entries. Dead slots may get marked too; that
            // is harmless because a push overwrites the whole slot.
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].addr == kill_addr) begin
                        mem[i].kill <= 1'b1;
                    end
                end
            end
            // The pushed slot is never live, so this write cannot collide
            // with a kill aimed at a real entry.
            if (push) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Age-ordered view: slot k is the k-th oldest entry, live when it holds
    // a queued result that has not been killed.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx         = rd_ptr + PW'(k);
            ent_live[k] = (CW'(k) < cnt) && !mem[idx].kill;
            ent_addr[k] = mem[idx].addr;
`ifdef WB_FORWARD_EN
            ent_data[k] = mem[idx].data;
`endif
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges the ALU stream (A) and buffered LSU/MUL-DIV stream (B) into one GPR write port.
// Latency: accepted A result is written 1 cycle later; B results queue in wb_fifo and pop in order.
// Backpressure: a_ready drops only for a forced drain; b_ready drops while the FIFO is full.
//
// Ports: clk, rst (async active-high); a_valid/a_ready/a_addr/a_data and
// b_valid/b_ready/b_addr/b_data are the two result streams; wr_en/addr_wr/
// data_wr is the registered register-file write; rd_addr1/rd_addr2 are decode
// queries answered by busy1/busy2.
// Optional WB_FORWARD_EN: adds fwd_data1/fwd_data2, the youngest live matching
// FIFO data; busyN then means "forwardable" rather than "stall".
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [`BUS_ADDR_REG] a_addr,
    input  logic [`BUS_DATA_REG] a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [`BUS_ADDR_REG] b_addr,
    input  logic [`BUS_DATA_REG] b_data,
    output logic                 wr_en,
    output logic [`BUS_ADDR_REG] addr_wr,
    output logic [`BUS_DATA_REG] data_wr,
    input  logic [`BUS_ADDR_REG] rd_addr1,
    input  logic [`BUS_ADDR_REG] rd_addr2,
    output logic                 busy1,
    output logic                 busy2
`ifdef WB_FORWARD_EN
    ,
    output logic [`BUS_DATA_REG] fwd_data1,
    output logic [`BUS_DATA_REG] fwd_data2
`endif
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    wb_entry_t            head;
    wb_entry_t            push_ent;
    logic                 empty;
    logic                 full;
    logic                 ent_live [DEPTH];
    logic [`BUS_ADDR_REG] ent_addr [DEPTH];
`ifdef WB_FORWARD_EN
    logic [`BUS_DATA_REG] ent_data [DEPTH];
`endif

    logic [SW-1:0] starve_cnt;
    logic          force_drain;
    logic          a_acc;
    logic          a_wr;
    logic          b_push;
    logic          pop;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign force_drain = (starve_cnt == STARVE_LIM) && !empty;
    assign a_ready     = !force_drain;
    assign b_ready     = !full;

    assign a_acc  = a_valid && a_ready;
    // An x0 result is consumed but never occupies the write port.
    assign a_wr   = a_acc && !is_x0(a_addr);
    assign b_push = b_valid && b_ready;
    // The head pops when forced, or whenever A does not claim the port.
    assign pop    = force_drain || (!a_wr && !empty);

    // B is older than a same-cycle A write to the same register, so it is
    // born dead; an x0 target is likewise never written.
    assign push_ent.addr = b_addr;
    assign push_ent.data = b_data;
    assign push_ent.kill = is_x0(b_addr) || (a_wr && (a_addr == b_addr));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_ent  (push_ent),
        .pop       (pop),
        .kill_en   (a_wr),
        .kill_addr (a_addr),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .ent_live  (ent_live),
        .ent_addr  (ent_addr)
`ifdef WB_FORWARD_EN
        ,
        .ent_data  (ent_data)
`endif
    );

    // ------------------------------------------------------------------
    // Starvation counter: counts cycles a non-empty FIFO is passed over.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            addr_wr <= `REG_ADDR_ZERO;
            data_wr <= `ZERO_WORD;
        end else if (a_wr) begin
            wr_en   <= `REG_WR_EN;
            addr_wr <= a_addr;
            data_wr <= a_data;
        end else if (pop) begin
            // A killed head still spends this cycle, but writes nothing.
            wr_en   <= !head.kill;
            addr_wr <= head.addr;
            data_wr <= head.data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending-write lookup. The output register is covered by the regfile
    // bypass, so only FIFO contents count. Scanning oldest to youngest lets
    // the youngest match win the forwarded data.
    // ------------------------------------------------------------------
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
`ifdef WB_FORWARD_EN
        fwd_data1 = `ZERO_WORD;
        fwd_data2 = `ZERO_WORD;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_live[k] && !is_x0(rd_addr1) && (ent_addr[k] == rd_addr1)) begin
                busy1 = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_data1 = ent_data[k];
`endif
            end
            if (ent_live[k] && !is_x0(rd_addr2) && (ent_addr[k] == rd_addr2)) begin
                busy2 = 1'b1;
`ifdef WB_FORWARD_EN
                fwd_data2 = ent_data[k];
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed stimulus with a write-port scoreboard.
// Expected register-file writes are queued as stimulus is issued; a monitor
// compares every wr_en pulse against the queue head. Handshake/busy outputs
// are checked directly at the falling edge.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_addr, b_addr, addr_wr, rd_addr1, rd_addr2;
    logic [31:0] a_data, b_data, data_wr;
    logic        wr_en, busy1, busy2;
`ifdef WB_FORWARD_EN
    logic [31:0] fwd_data1, fwd_data2;
`endif

    reg_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .wr_en    (wr_en),
        .addr_wr  (addr_wr),
        .data_wr  (data_wr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .busy1    (busy1),
        .busy2    (busy2)
`ifdef WB_FORWARD_EN
        ,
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic expw(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exq.push_back(e);
    endtask

    task automatic setab(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic idle();
        setab(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Advance from just after one rising edge to just after the next.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en !== 1'b0) begin
            checks++;
            if (exq.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected: got wr_en=%0b addr=%0d data=0x%0h, none expected at %0t",
                         wr_en, addr_wr, data_wr, $time);
            end else begin
                exp_t e;
                e = exq.pop_front();
                if (wr_en !== 1'b1 || addr_wr !== e.addr || data_wr !== e.data) begin
                    failures++;
                    $display("FAIL wr_port: got wr_en=%0b addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                             wr_en, addr_wr, data_wr, e.addr, e.data, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        idle();
        @(negedge clk);
        chk("rst_wr_en",   wr_en,   0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_addr_wr", addr_wr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // ---- 1: reset with three B entries queued behind a busy A ----
        setab(1, 5'd1, 32'h11, 1, 5'd2, 32'h22); expw(5'd1, 32'h11); step();
        setab(1, 5'd1, 32'h12, 1, 5'd3, 32'h33); expw(5'd1, 32'h12); step();
        setab(1, 5'd1, 32'h13, 1, 5'd4, 32'h44); expw(5'd1, 32'h13); step();
        idle();
        rd_addr1 = 5'd3;
        @(negedge clk);
        chk("t1_busy_before_rst", busy1, 1);
        #1 rst = 1'b1;
        #1;
        chk("t1_rst_wr_en",   wr_en,   0);
        chk("t1_rst_b_ready", b_ready, 1);
        chk("t1_rst_busy1",   busy1,   0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_addr1 = 5'd0;
        repeat (3) step();   // discarded entries must never be written

        // ---- 2: A only, then an x0 write ----
        setab(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0); expw(5'd5, 32'h1234); step();
        setab(1, 5'd0, 32'h9999, 0, 5'd0, 32'h0);
        @(negedge clk);
        chk("t2_wr_en",   wr_en,   1);
        chk("t2_addr_wr", addr_wr, 5);
        chk("t2_data_wr", data_wr, 32'h1234);
        chk("t2_x0_a_ready", a_ready, 1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("t2_x0_wr_en", wr_en, 0);
        @(posedge clk); #1;

        // ---- 3: starvation forces a drain after 3 passed-over cycles ----
        setab(1, 5'd1, 32'hA0, 1, 5'd7, 32'h77); expw(5'd1, 32'hA0); step();
        setab(1, 5'd1, 32'hA1, 0, 5'd0, 32'h0);  expw(5'd1, 32'hA1);
        @(negedge clk); chk("t3_a_ready_c1", a_ready, 1); @(posedge clk); #1;
        setab(1, 5'd1, 32'hA2, 0, 5'd0, 32'h0);  expw(5'd1, 32'hA2); step();
        setab(1, 5'd1, 32'hA3, 0, 5'd0, 32'h0);  expw(5'd1, 32'hA3);
        @(negedge clk); chk("t3_a_ready_c3", a_ready, 1); @(posedge clk); #1;
        setab(1, 5'd1, 32'hA4, 0, 5'd0, 32'h0);  expw(5'd7, 32'h77);
        @(negedge clk); chk("t3_force_drain", a_ready, 0); @(posedge clk); #1;
        expw(5'd1, 32'hA4);
        @(negedge clk); chk("t3_a_resume", a_ready, 1); @(posedge clk); #1;
        idle(); step();

        // ---- 4: fill the FIFO; a pop does not free a slot the same cycle ----
        setab(1, 5'd1, 32'hB0, 1, 5'd10, 32'h100); expw(5'd1, 32'hB0);
        @(negedge clk); chk("t4_b_ready_empty", b_ready, 1); @(posedge clk); #1;
        setab(1, 5'd1, 32'hB1, 1, 5'd11, 32'h101); expw(5'd1, 32'hB1); step();
        setab(1, 5'd1, 32'hB2, 1, 5'd12, 32'h102); expw(5'd1, 32'hB2); step();
        setab(1, 5'd1, 32'hB3, 1, 5'd13, 32'h103); expw(5'd1, 32'hB3); step();
        setab(1, 5'd1, 32'hB4, 1, 5'd14, 32'h104); expw(5'd10, 32'h100);
        @(negedge clk);
        chk("t4_full_b_ready", b_ready, 0);
        chk("t4_full_drain",   a_ready, 0);
        @(posedge clk); #1;
        setab(1, 5'd1, 32'hB4, 0, 5'd0, 32'h0); expw(5'd1, 32'hB4);
        @(negedge clk);
        chk("t4_b_ready_after_pop", b_ready, 1);
        chk("t4_a_ready_after_pop", a_ready, 1);
        @(posedge clk); #1;
        idle();
        expw(5'd11, 32'h101); expw(5'd12, 32'h102); expw(5'd13, 32'h103);
        repeat (5) step();

        // ---- 5: WAW squash, same-cycle kill, x0 push ----
        setab(1, 5'd2, 32'hC0, 1, 5'd9, 32'hAA); expw(5'd2, 32'hC0); step();
        setab(1, 5'd9, 32'hBB, 0, 5'd0, 32'h0);  expw(5'd9, 32'hBB);
        rd_addr1 = 5'd9;
        @(negedge clk); chk("t5_busy_pre_kill", busy1, 1); @(posedge clk); #1;
        idle();
        @(negedge clk); chk("t5_busy_post_kill", busy1, 0); @(posedge clk); #1;
        @(negedge clk); chk("t5_killed_pop_wr_en", wr_en, 0); @(posedge clk); #1;
        setab(1, 5'd6, 32'hD0, 1, 5'd6, 32'hE0); expw(5'd6, 32'hD0);
        rd_addr2 = 5'd6;
        step();
        idle();
        @(negedge clk); chk("t5_same_cycle_kill_busy2", busy2, 0); @(posedge clk); #1;
        setab(0, 5'd0, 32'h0, 1, 5'd0, 32'hF0); step();
        idle(); rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        repeat (3) step();

        // ---- 6: busy / forward, x0 A does not block a pop ----
        setab(1, 5'd4, 32'hE1, 1, 5'd3, 32'h55); expw(5'd4, 32'hE1); step();
        setab(1, 5'd4, 32'hE2, 0, 5'd0, 32'h0);  expw(5'd4, 32'hE2);
        rd_addr1 = 5'd3; rd_addr2 = 5'd3;
        @(negedge clk);
        chk("t6_busy1", busy1, 1);
        chk("t6_busy2", busy2, 1);
`ifdef WB_FORWARD_EN
        chk("t6_fwd_data1", fwd_data1, 32'h55);
`endif
        rd_addr1 = 5'd0;
        #1;
        chk("t6_busy1_x0", busy1, 0);
        chk("t6_busy2_hold", busy2, 1);
        @(posedge clk); #1;
        setab(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'h0); expw(5'd3, 32'h55);
        @(negedge clk); chk("t6_x0_a_ready", a_ready, 1); @(posedge clk); #1;
        idle();
        @(negedge clk); chk("t6_busy2_popped", busy2, 0); @(posedge clk); #1;
        rd_addr2 = 5'd0;
        repeat (4) step();

        chk("leftover_expected_writes", exq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
